// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and the PLL plus the
// PLL-clocked logic it releases. The sequencer is the master.
interface pll_reset_sequencer_if #(
  parameter int unsigned RW = 2
);
  logic          pll_locked;
  logic          pll_rst;
  logic          sys_reset;
  logic          ready;
  logic          fail;
  logic          lock_loss;
  logic [RW-1:0] retry_count;

  modport master (
    input  pll_locked,
    output pll_rst, sys_reset, ready, fail, lock_loss, retry_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst, sys_reset, ready, fail, lock_loss, retry_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock (with retries on
// timeout), requires lock to be stable before releasing the system reset, and
// re-sequences the PLL when lock is lost. Runs on the board reference clock.
module pll_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  pll_reset_sequencer_if.master bus
);

  localparam int unsigned RW_RAW = $clog2(MAX_RETRIES + 1);
  localparam int unsigned RW     = (RW_RAW < 1) ? 1 : RW_RAW;

  localparam int unsigned MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLLRST    = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lock_m;
  logic          lock_s;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= bus.pll_locked;
      lock_s <= lock_m;
    end
  end

  // Sequencing FSM; every output is a flop loaded on the transition edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= PLLRST;
      cnt             <= '0;
      bus.pll_rst     <= 1'b1;
      bus.sys_reset   <= 1'b1;
      bus.ready       <= 1'b0;
      bus.fail        <= 1'b0;
      bus.lock_loss   <= 1'b0;
      bus.retry_count <= '0;
    end else begin
      bus.lock_loss <= 1'b0;
      case (state)
        PLLRST: begin
          if (cnt == RST_LAST) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            bus.pll_rst <= 1'b0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // Lock has priority over a timeout landing on the same cycle.
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt <= '0;
            if (bus.retry_count == RETRY_LIMIT) begin
              state    <= FAIL;
              bus.fail <= 1'b1;
            end else begin
              state           <= PLLRST;
              bus.pll_rst     <= 1'b1;
              bus.retry_count <= bus.retry_count + 1'b1;
            end
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE: begin
          // A lock glitch restarts the full timeout without costing a retry.
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state           <= RUN;
            cnt             <= '0;
            bus.sys_reset   <= 1'b0;
            bus.ready       <= 1'b1;
            bus.retry_count <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state           <= PLLRST;
            cnt             <= '0;
            bus.pll_rst     <= 1'b1;
            bus.sys_reset   <= 1'b1;
            bus.ready       <= 1'b0;
            bus.lock_loss   <= 1'b1;
            bus.retry_count <= '0;
          end
        end
        FAIL: begin
          bus.pll_rst   <= 1'b0;
          bus.sys_reset <= 1'b1;
          bus.ready     <= 1'b0;
          bus.fail      <= 1'b1;
        end
        default: begin
          state         <= PLLRST;
          cnt           <= '0;
          bus.pll_rst   <= 1'b1;
          bus.sys_reset <= 1'b1;
          bus.ready     <= 1'b0;
          bus.fail      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

  localparam int unsigned RW = 2;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  pll_reset_sequencer_if #(.RW(RW)) bus ();

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (50),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reset held across two edges, released 1 time unit after an edge (edge e1 is next).
  task automatic do_reset();
    bus.pll_locked = 1'b0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    bus.pll_locked = 1'b0;
    reset = 1'b1;
    step(2);

    // Reset state
    chk1("rst_pll_rst",   bus.pll_rst,   1'b1);
    chk1("rst_sys_reset", bus.sys_reset, 1'b1);
    chk1("rst_ready",     bus.ready,     1'b0);
    chk1("rst_fail",      bus.fail,      1'b0);
    chk1("rst_lock_loss", bus.lock_loss, 1'b0);
    chkn("rst_retry",     bus.retry_count, 2'd0);

    // 1: normal bring-up, lock 20 cycles after reset release
    reset = 1'b0;
    step(3);
    chk1("t1_pll_rst_e3", bus.pll_rst, 1'b1);
    step(1);
    chk1("t1_pll_rst_e4", bus.pll_rst, 1'b0);
    chk1("t1_sysrst_e4",  bus.sys_reset, 1'b1);
    step(16);
    bus.pll_locked = 1'b1;
    step(10);
    chk1("t1_ready_edge9",  bus.ready,     1'b0);
    chk1("t1_sysrst_edge9", bus.sys_reset, 1'b1);
    step(1);
    chk1("t1_ready_edge10",  bus.ready,     1'b1);
    chk1("t1_sysrst_edge10", bus.sys_reset, 1'b0);
    chk1("t1_pll_rst_run",   bus.pll_rst,   1'b0);
    chkn("t1_retry",         bus.retry_count, 2'd0);

    // 2: one-cycle lock dropout while STABLE cnt==5
    do_reset();
    step(4);
    bus.pll_locked = 1'b1;
    step(6);
    bus.pll_locked = 1'b0;
    step(1);
    bus.pll_locked = 1'b1;
    step(1);
    step(9);
    chk1("t2_ready_ret9", bus.ready, 1'b0);
    chkn("t2_retry_ret9", bus.retry_count, 2'd0);
    step(1);
    chk1("t2_ready_ret10",  bus.ready,     1'b1);
    chk1("t2_sysrst_ret10", bus.sys_reset, 1'b0);
    chkn("t2_retry_ret10",  bus.retry_count, 2'd0);

    // 6: lock arrives exactly on the timeout cycle of the first retry
    do_reset();
    step(54);
    chk1("t6_pll_rst_e54", bus.pll_rst, 1'b1);
    chkn("t6_retry_e54",   bus.retry_count, 2'd1);
    step(51);
    bus.pll_locked = 1'b1;
    step(3);
    chk1("t6_pll_rst_e108", bus.pll_rst, 1'b0);
    chkn("t6_retry_e108",   bus.retry_count, 2'd1);
    chk1("t6_fail_e108",    bus.fail, 1'b0);
    step(7);
    chk1("t6_ready_e115", bus.ready, 1'b0);
    chkn("t6_retry_e115", bus.retry_count, 2'd1);
    step(1);
    chk1("t6_ready_e116", bus.ready, 1'b1);
    chkn("t6_retry_e116", bus.retry_count, 2'd0);

    // 4: lock loss while in RUN, then relock
    do_reset();
    step(4);
    bus.pll_locked = 1'b1;
    step(11);
    chk1("t4_ready_pre", bus.ready, 1'b1);
    bus.pll_locked = 1'b0;
    step(2);
    chk1("t4_ready_edge1", bus.ready,     1'b1);
    chk1("t4_ll_edge1",    bus.lock_loss, 1'b0);
    step(1);
    chk1("t4_ll_edge2",     bus.lock_loss, 1'b1);
    chk1("t4_sysrst_edge2", bus.sys_reset, 1'b1);
    chk1("t4_ready_edge2",  bus.ready,     1'b0);
    chk1("t4_pll_rst_e2",   bus.pll_rst,   1'b1);
    step(1);
    chk1("t4_ll_edge3",   bus.lock_loss, 1'b0);
    chk1("t4_pll_rst_e3", bus.pll_rst,   1'b1);
    step(2);
    chk1("t4_pll_rst_e5", bus.pll_rst, 1'b1);
    step(1);
    chk1("t4_pll_rst_e6", bus.pll_rst, 1'b0);
    bus.pll_locked = 1'b1;
    step(11);
    chk1("t4_relock_ready",  bus.ready,     1'b1);
    chk1("t4_relock_sysrst", bus.sys_reset, 1'b0);
    chkn("t4_relock_retry",  bus.retry_count, 2'd0);

    // 5: async reset asserted between edges while STABLE
    do_reset();
    step(4);
    bus.pll_locked = 1'b1;
    step(6);
    chk1("t5_pll_rst_before", bus.pll_rst, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk1("t5_pll_rst_async", bus.pll_rst,   1'b1);
    chk1("t5_sysrst_async",  bus.sys_reset, 1'b1);
    chk1("t5_ready_async",   bus.ready,     1'b0);
    chk1("t5_fail_async",    bus.fail,      1'b0);

    // 3: lock never arrives -> three attempts then FAIL
    do_reset();
    step(3);
    chk1("t3_pll_rst_e3", bus.pll_rst, 1'b1);
    step(1);
    chk1("t3_pll_rst_e4", bus.pll_rst, 1'b0);
    chkn("t3_retry_e4",   bus.retry_count, 2'd0);
    step(49);
    chk1("t3_pll_rst_e53", bus.pll_rst, 1'b0);
    chkn("t3_retry_e53",   bus.retry_count, 2'd0);
    step(1);
    chk1("t3_pll_rst_e54", bus.pll_rst, 1'b1);
    chkn("t3_retry_e54",   bus.retry_count, 2'd1);
    step(3);
    chk1("t3_pll_rst_e57", bus.pll_rst, 1'b1);
    step(1);
    chk1("t3_pll_rst_e58", bus.pll_rst, 1'b0);
    step(50);
    chk1("t3_pll_rst_e108", bus.pll_rst, 1'b1);
    chkn("t3_retry_e108",   bus.retry_count, 2'd2);
    step(4);
    chk1("t3_pll_rst_e112", bus.pll_rst, 1'b0);
    step(49);
    chk1("t3_fail_e161", bus.fail, 1'b0);
    step(1);
    chk1("t3_fail_e162",    bus.fail,      1'b1);
    chk1("t3_pll_rst_e162", bus.pll_rst,   1'b0);
    chk1("t3_sysrst_e162",  bus.sys_reset, 1'b1);
    chkn("t3_retry_e162",   bus.retry_count, 2'd2);
    bus.pll_locked = 1'b1;
    step(200);
    chk1("t3_fail_held",   bus.fail,      1'b1);
    chk1("t3_sysrst_held", bus.sys_reset, 1'b1);
    chk1("t3_ready_held",  bus.ready,     1'b0);
    chk1("t3_pllrst_held", bus.pll_rst,   1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk1("t3_fail_async_clr", bus.fail,    1'b0);
    chk1("t3_pll_rst_async",  bus.pll_rst, 1'b1);
    reset = 1'b0;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
